// File: rtl/cix32_mem_model.sv
// Dual-port (fetch + data) byte-array memory model with per-port wait states and access counters.
// Optional feature macro: CIX32_MEM_RAND_STALL_EN adds 0..3 LFSR-driven extra wait cycles per access.
module cix32_mem_model #(
  parameter int          DEPTH_BYTES  = 4096,
  parameter int          IMEM_LATENCY = 1,
  parameter int          DMEM_LATENCY = 1,
  parameter logic [7:0]  FILL_BYTE    = 8'h90,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic [31:0] imem_count,
  output logic [31:0] dmem_rd_count,
  output logic [31:0] dmem_wr_count
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [AW-1:0] A2 = AW'(2);
  localparam logic [AW-1:0] A3 = AW'(3);
  localparam logic [31:0] I_WAIT = 32'(IMEM_LATENCY - 1);
  localparam logic [31:0] D_WAIT = 32'(DMEM_LATENCY - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  logic [7:0]    r_mem [DEPTH_BYTES];
  state_t        r_i_state, r_d_state;
  logic [31:0]   r_i_cnt, r_d_cnt;
  logic [31:0]   r_i_snap, r_d_snap;
  logic          r_d_is_wr;

  logic [AW-1:0] w_i_a0, w_d_a0;
  logic [31:0]   w_i_word, w_d_word;
  logic          w_i_accept, w_d_accept;
  logic [31:0]   w_i_extra, w_d_extra;
  logic          w_unused_bits;

  // Contents exist only from time zero; reset never touches the array.
  initial begin
    for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] = FILL_BYTE;
  end

  assign w_i_a0 = imem_addr[AW-1:0];
  assign w_d_a0 = {dmem_addr[AW-1:2], 2'b00};
  assign w_i_word = {r_mem[w_i_a0 + A3], r_mem[w_i_a0 + A2], r_mem[w_i_a0 + A1], r_mem[w_i_a0]};
  assign w_d_word = {r_mem[w_d_a0 + A3], r_mem[w_d_a0 + A2], r_mem[w_d_a0 + A1], r_mem[w_d_a0]};
  assign w_i_accept = rst_n && (r_i_state == ST_IDLE) && imem_req;
  assign w_d_accept = rst_n && (r_d_state == ST_IDLE) && dmem_req;
  assign w_unused_bits = ^{imem_addr[31:AW], dmem_addr[31:AW], dmem_addr[1:0]};

`ifdef CIX32_MEM_RAND_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_i_extra = {30'd0, r_lfsr[1:0]};
  assign w_d_extra = {30'd0, r_lfsr[3:2]};
`else
  assign w_i_extra = 32'd0;
  assign w_d_extra = 32'd0;
`endif

  // Write commit at the accept edge; same-edge fetches still see the old bytes.
  always_ff @(posedge clk) begin
    if (w_d_accept && dmem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_wstrb[i]) r_mem[w_d_a0 + AW'(i)] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  // Fetch port: snapshot on accept, count down wait states, pulse ready for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_state  <= ST_IDLE;
      r_i_cnt    <= 32'd0;
      r_i_snap   <= 32'd0;
      imem_ready <= 1'b0;
      imem_rdata <= 32'd0;
      imem_count <= 32'd0;
    end else begin
      case (r_i_state)
        ST_IDLE: begin
          imem_ready <= 1'b0;
          if (w_i_accept) begin
            r_i_snap   <= w_i_word;
            r_i_cnt    <= I_WAIT + w_i_extra;
            r_i_state  <= ST_WAIT;
            imem_count <= (imem_count == 32'hFFFF_FFFF) ? imem_count : imem_count + 32'd1;
          end
        end
        ST_WAIT: begin
          if (r_i_cnt == 32'd0) begin
            imem_ready <= 1'b1;
            imem_rdata <= r_i_snap;
            r_i_state  <= ST_IDLE;
          end else begin
            r_i_cnt <= r_i_cnt - 32'd1;
          end
        end
        default: begin
          r_i_state  <= ST_IDLE;
          imem_ready <= 1'b0;
        end
      endcase
    end
  end

  // Data port: same handshake; write responses leave dmem_rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_state     <= ST_IDLE;
      r_d_cnt       <= 32'd0;
      r_d_snap      <= 32'd0;
      r_d_is_wr     <= 1'b0;
      dmem_ready    <= 1'b0;
      dmem_rdata    <= 32'd0;
      dmem_rd_count <= 32'd0;
      dmem_wr_count <= 32'd0;
    end else begin
      case (r_d_state)
        ST_IDLE: begin
          dmem_ready <= 1'b0;
          if (w_d_accept) begin
            r_d_is_wr <= dmem_we;
            r_d_cnt   <= D_WAIT + w_d_extra;
            r_d_state <= ST_WAIT;
            if (dmem_we) begin
              dmem_wr_count <= (dmem_wr_count == 32'hFFFF_FFFF) ? dmem_wr_count : dmem_wr_count + 32'd1;
            end else begin
              r_d_snap      <= w_d_word;
              dmem_rd_count <= (dmem_rd_count == 32'hFFFF_FFFF) ? dmem_rd_count : dmem_rd_count + 32'd1;
            end
          end
        end
        ST_WAIT: begin
          if (r_d_cnt == 32'd0) begin
            dmem_ready <= 1'b1;
            if (!r_d_is_wr) dmem_rdata <= r_d_snap;
            r_d_state <= ST_IDLE;
          end else begin
            r_d_cnt <= r_d_cnt - 32'd1;
          end
        end
        default: begin
          r_d_state  <= ST_IDLE;
          dmem_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cix32_mem_model.sv
// Scoreboard bench for cix32_mem_model: a default-latency instance plus a slow (3/4-cycle) instance.
module tb_cix32_mem_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic        i_req, i_ready, d_req, d_we, d_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, i_cnt, d_rd_cnt, d_wr_cnt;
  logic [3:0]  d_wstrb;
  logic        i_req2, i_ready2, d_req2, d_we2, d_ready2;
  logic [31:0] i_addr2, i_rdata2, d_addr2, d_wdata2, d_rdata2, i_cnt2, d_rd_cnt2, d_wr_cnt2;
  logic [3:0]  d_wstrb2;

  cix32_mem_model u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(i_req), .imem_addr(i_addr), .imem_rdata(i_rdata), .imem_ready(i_ready),
    .dmem_req(d_req), .dmem_we(d_we), .dmem_addr(d_addr), .dmem_wdata(d_wdata),
    .dmem_wstrb(d_wstrb), .dmem_rdata(d_rdata), .dmem_ready(d_ready),
    .imem_count(i_cnt), .dmem_rd_count(d_rd_cnt), .dmem_wr_count(d_wr_cnt)
  );

  cix32_mem_model #(.IMEM_LATENCY(3), .DMEM_LATENCY(4)) u_slow (
    .clk(clk), .rst_n(rst2_n),
    .imem_req(i_req2), .imem_addr(i_addr2), .imem_rdata(i_rdata2), .imem_ready(i_ready2),
    .dmem_req(d_req2), .dmem_we(d_we2), .dmem_addr(d_addr2), .dmem_wdata(d_wdata2),
    .dmem_wstrb(d_wstrb2), .dmem_rdata(d_rdata2), .dmem_ready(d_ready2),
    .imem_count(i_cnt2), .dmem_rd_count(d_rd_cnt2), .dmem_wr_count(d_wr_cnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
  } dexp_t;

  logic [31:0] iq[$];
  dexp_t       dq[$];
  logic [31:0] last_rd = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Fetch-port monitor: compare every response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && i_ready) begin
      if (iq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL imem_unexpected_ready: got data %h expected no response", i_rdata);
      end else begin
        check32("imem_rdata", i_rdata, iq.pop_front());
      end
    end
  end

  // Data-port monitor: reads check the word, writes check rdata is held.
  always @(negedge clk) begin
    if (rst_n && d_ready) begin
      if (dq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dmem_unexpected_ready: got data %h expected no response", d_rdata);
      end else begin
        dexp_t e;
        e = dq.pop_front();
        check32(e.wr ? "dmem_wr_rdata_hold" : "dmem_rdata", d_rdata, e.data);
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
    int waited = 0;
    iq.push_back(exp);
    i_req = 1'b1; i_addr = a;
    do begin
      @(posedge clk); #1; waited++;
    end while (!i_ready && waited < 30);
    i_req = 1'b0;
    check32("imem_latency", 32'(waited), 32'd2);
  endtask

  task automatic dtxn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [31:0] exp);
    int waited = 0;
    dexp_t e;
    e.wr = we;
    e.data = we ? last_rd : exp;
    if (!we) last_rd = exp;
    dq.push_back(e);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = strb;
    do begin
      @(posedge clk); #1; waited++;
    end while (!d_ready && waited < 30);
    d_req = 1'b0;
    check32("dmem_latency", 32'(waited), 32'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n = 1'b1; rst2_n = 1'b1;
    i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
    i_req2 = 1'b0; i_addr2 = 32'd0; d_req2 = 1'b0; d_we2 = 1'b0;
    d_addr2 = 32'd0; d_wdata2 = 32'd0; d_wstrb2 = 4'd0;
    #1 rst_n = 1'b0; rst2_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_imem_ready", {31'd0, i_ready}, 32'd0);
    check32("rst_imem_rdata", i_rdata, 32'd0);
    check32("rst_dmem_ready", {31'd0, d_ready}, 32'd0);
    check32("rst_dmem_rdata", d_rdata, 32'd0);
    check32("rst_counts", i_cnt | d_rd_cnt | d_wr_cnt | i_cnt2, 32'd0);
    @(negedge clk); rst_n = 1'b1; rst2_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check32("idle_ready", {30'd0, i_ready, d_ready}, 32'd0);
    check32("idle_rdata", i_rdata | d_rdata, 32'd0);
    check32("idle_counts", i_cnt | d_rd_cnt | d_wr_cnt, 32'd0);

    // Byte strobes and zero-strobe write
    @(negedge clk);
    dtxn(1'b1, 32'h102, 32'h12345678, 4'b0101, 32'd0);
    dtxn(1'b0, 32'h100, 32'd0, 4'd0, 32'h90349078);
    check32("wr_count_1", d_wr_cnt, 32'd1);
    check32("rd_count_1", d_rd_cnt, 32'd1);
    dtxn(1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 32'd0);
    dtxn(1'b0, 32'h100, 32'hFFFFFFFF, 4'b1111, 32'h90349078);
    check32("wr_count_2", d_wr_cnt, 32'd2);

    // Aliased reset-vector fetch and wrapped unaligned fetches
    dtxn(1'b1, 32'hFF0, 32'hB8484040, 4'b1111, 32'd0);
    fetch(32'h000FFFF0, 32'hB8484040);
    dtxn(1'b1, 32'hFFC, 32'h22110000, 4'b1100, 32'd0);
    dtxn(1'b1, 32'h000, 32'h00004433, 4'b0011, 32'd0);
    fetch(32'hFFE, 32'h44332211);
    fetch(32'hFF1, 32'h90B84840);
    dtxn(1'b0, 32'h00001FFF, 32'd0, 4'd0, 32'h22119090);

    // Same-edge fetch and write: fetch sees old data
    fork
      fetch(32'h200, 32'h90909090);
      dtxn(1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 32'd0);
    join
    fetch(32'h200, 32'hDEADBEEF);
    check32("imem_count", i_cnt, 32'd5);
    check32("wr_count_final", d_wr_cnt, 32'd6);
    check32("rd_count_final", d_rd_cnt, 32'd3);

    // Latency 3 with req held: ready every 4th edge
    @(negedge clk);
    i_req2 = 1'b1; i_addr2 = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check32("lat3_ready", {31'd0, i_ready2}, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) check32("lat3_rdata", i_rdata2, 32'h90909090);
    end
    check32("lat3_count", i_cnt2, 32'd5);
    @(negedge clk); i_req2 = 1'b0;

    // Reset during the wait phase of a committed write
    @(negedge clk);
    d_req2 = 1'b1; d_we2 = 1'b1; d_addr2 = 32'h40; d_wdata2 = 32'hCAFEF00D; d_wstrb2 = 4'hF;
    @(posedge clk);
    @(negedge clk); d_req2 = 1'b0;
    @(posedge clk);
    @(negedge clk); rst2_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check32("midrst_ready", {31'd0, d_ready2}, 32'd0);
    end
    check32("midrst_counts", i_cnt2 | d_rd_cnt2 | d_wr_cnt2, 32'd0);
    @(negedge clk); rst2_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check32("postrst_ready", {31'd0, d_ready2}, 32'd0);
    end
    @(negedge clk);
    d_req2 = 1'b1; d_we2 = 1'b0;
    waited = 0;
    do begin
      @(posedge clk); #1; waited++;
    end while (!d_ready2 && waited < 30);
    d_req2 = 1'b0;
    check32("lat4_latency", 32'(waited), 32'd5);
    check32("persist_rdata", d_rdata2, 32'hCAFEF00D);
    check32("persist_rd_count", d_rd_cnt2, 32'd1);
    check32("persist_wr_count", d_wr_cnt2, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check32("scoreboard_drained", 32'(iq.size() + dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
